vote_collector: RTL and testbench

Sequential front end for the 5-voter, 3-candidate majority voter. Accepts individual votes one at a time over a valid/ack interface, records one one-hot ballot per voter, and closes the round when all voters have voted or a timeout expires. Then presents the five 3-bit ballots to the voter inputs with a valid/ready handshake. Voters who did not vote are presented as abstentions (3'b000).

---
 rtl/vote_pkg.sv | 27 ++
 rtl/vote_collector_if.sv | 34 +++
 rtl/round_timer.sv | 31 +++
 rtl/vote_collector.sv | 100 ++++++++++
 tb/tb_vote_collector.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the vote collector front end.
// Ballots are one-hot per candidate; 000 means abstain.
package vote_pkg;

  localparam int N_VOTERS = 5;
  localparam int CAND_W   = 3;
  localparam int TIMER_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    CLOSED
  } state_t;

  function automatic logic [CAND_W-1:0] sel_to_onehot(input logic [1:0] sel);
    logic [CAND_W-1:0] onehot;
    onehot = '0;
    case (sel)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/vote_collector_if.sv
// Vote intake and ballot delivery signals between the collector and its
// environment. master = vote source / ballot consumer, slave = collector.
interface vote_collector_if;
  import vote_pkg::*;

  logic                start;
  logic                vote_valid;
  logic [2:0]          vote_id;
  logic [1:0]          vote_sel;
  logic                vote_ack;
  logic                vote_nak;
  logic                busy;
  logic [N_VOTERS-1:0] voted_mask;
  logic                ballot_valid;
  logic                ballot_ready;
  logic [CAND_W-1:0]   ballot_1;
  logic [CAND_W-1:0]   ballot_2;
  logic [CAND_W-1:0]   ballot_3;
  logic [CAND_W-1:0]   ballot_4;
  logic [CAND_W-1:0]   ballot_5;

  modport master (
    output start, vote_valid, vote_id, vote_sel, ballot_ready,
    input  vote_ack, vote_nak, busy, voted_mask, ballot_valid,
           ballot_1, ballot_2, ballot_3, ballot_4, ballot_5
  );

  modport slave (
    input  start, vote_valid, vote_id, vote_sel, ballot_ready,
    output vote_ack, vote_nak, busy, voted_mask, ballot_valid,
           ballot_1, ballot_2, ballot_3, ballot_4, ballot_5
  );

endinterface

// File: rtl/round_timer.sv
// Round length counter: cleared when a round opens, counts open cycles,
// and flags the last cycle of the round combinationally.
module round_timer
  import vote_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [TIMER_W-1:0] r_count;

  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign o_expire = (r_count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/vote_collector.sv
// Collects one vote per voter over valid/ack, closes the round on a full
// mask or timeout, then holds the five ballots until the consumer takes them.
module vote_collector
  import vote_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  vote_collector_if.slave  bus
);

  state_t              r_state;
  state_t              w_next_state;
  logic [CAND_W-1:0]   r_ballot [N_VOTERS];
  logic [N_VOTERS-1:0] r_mask;
  logic                r_ack;
  logic                r_nak;

  logic                w_start_round;
  logic                w_expire;
  logic                w_timer_expire;
  logic                w_id_ok;
  logic                w_sel_ok;
  logic                w_accept;
  logic                w_all_voted;
  logic [N_VOTERS-1:0] w_id_bit;

  round_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start_round),
    .i_enable (r_state == OPEN),
    .o_expire (w_timer_expire)
  );

  // Out-of-range ids shift the bit off the top and give an all-zero select.
  assign w_id_bit    = N_VOTERS'(1) << bus.vote_id;
  assign w_id_ok     = bus.vote_id < 3'(N_VOTERS);
  assign w_sel_ok    = bus.vote_sel < 2'(CAND_W);
  assign w_accept    = (r_state == OPEN) && bus.vote_valid && w_id_ok && w_sel_ok
                       && ((r_mask & w_id_bit) == '0);
  assign w_all_voted = &(r_mask | (w_accept ? w_id_bit : '0));
  assign w_expire    = w_timer_expire && (r_state == OPEN);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_start_round = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next_state  = OPEN;
          w_start_round = 1'b1;
        end
      end
      OPEN:    if (w_all_voted || w_expire) w_next_state = CLOSED;
      CLOSED:  if (bus.ballot_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: the ballot array drives output ports directly, so it is reset
  // like any other register rather than left as uninitialised storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_ack   <= 1'b0;
      r_nak   <= 1'b0;
      for (int i = 0; i < N_VOTERS; i++) r_ballot[i] <= '0;
    end else begin
      r_state <= w_next_state;
      r_ack   <= w_accept;
      r_nak   <= bus.vote_valid && !w_accept;
      if (w_start_round) begin
        r_mask <= '0;
        for (int i = 0; i < N_VOTERS; i++) r_ballot[i] <= '0;
      end else if (w_accept) begin
        r_mask <= r_mask | w_id_bit;
        for (int i = 0; i < N_VOTERS; i++) begin
          if (w_id_bit[i]) r_ballot[i] <= sel_to_onehot(bus.vote_sel);
        end
      end
    end
  end

  assign bus.vote_ack     = r_ack;
  assign bus.vote_nak     = r_nak;
  assign bus.busy         = (r_state != IDLE);
  assign bus.ballot_valid = (r_state == CLOSED);
  assign bus.voted_mask   = r_mask;
  assign bus.ballot_1     = r_ballot[0];
  assign bus.ballot_2     = r_ballot[1];
  assign bus.ballot_3     = r_ballot[2];
  assign bus.ballot_4     = r_ballot[3];
  assign bus.ballot_5     = r_ballot[4];

endmodule

// File: tb/tb_vote_collector.sv
// Directed scenarios plus a randomized run against a choice-list model of
// the voting round (who voted for what, how long the round has been open).
module tb_vote_collector;
  import vote_pkg::*;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vote_collector_if bus();

  vote_collector #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: candidate chosen by each voter (-1 = not voted).
  bit m_collecting;
  bit m_delivering;
  int m_elapsed;
  int m_choice [N_VOTERS];
  bit m_ack;
  bit m_nak;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start        = 1'b0;
    bus.vote_valid   = 1'b0;
    bus.vote_id      = 3'd0;
    bus.vote_sel     = 2'd0;
    bus.ballot_ready = 1'b0;
  endtask

  task automatic set_vote(input bit v, input int id, input int sel);
    bus.vote_valid = v;
    bus.vote_id    = 3'(id);
    bus.vote_sel   = 2'(sel);
  endtask

  function automatic logic [14:0] ballots_flat();
    return {bus.ballot_1, bus.ballot_2, bus.ballot_3, bus.ballot_4, bus.ballot_5};
  endfunction

  task automatic model_reset();
    m_collecting = 1'b0;
    m_delivering = 1'b0;
    m_elapsed    = 0;
    m_ack        = 1'b0;
    m_nak        = 1'b0;
    foreach (m_choice[i]) m_choice[i] = -1;
  endtask

  task automatic model_edge(input bit st, input bit vv, input int id, input int sel, input bit rdy);
    bit acc;
    int voted;
    acc = 1'b0;
    if (m_collecting && vv && id < N_VOTERS && sel < CAND_W) acc = (m_choice[id] < 0);
    m_ack = acc;
    m_nak = vv && !acc;
    if (m_delivering) begin
      if (rdy) m_delivering = 1'b0;
    end else if (m_collecting) begin
      if (acc) m_choice[id] = sel;
      voted = 0;
      foreach (m_choice[i]) if (m_choice[i] >= 0) voted++;
      if (voted == N_VOTERS || m_elapsed == int'(TO) - 1) begin
        m_collecting = 1'b0;
        m_delivering = 1'b1;
      end else begin
        m_elapsed++;
      end
    end else if (st) begin
      m_collecting = 1'b1;
      m_elapsed    = 0;
      foreach (m_choice[i]) m_choice[i] = -1;
    end
  endtask

  function automatic logic [23:0] model_outputs();
    logic [4:0]  mask;
    logic [14:0] b;
    for (int i = 0; i < N_VOTERS; i++) begin
      mask[i]          = (m_choice[i] >= 0);
      b[14-3*i -: 3]   = (m_choice[i] < 0) ? 3'b000 : 3'(1 << m_choice[i]);
    end
    return {m_collecting || m_delivering, m_ack, m_nak, m_delivering, mask, b};
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({bus.busy, bus.vote_ack, bus.vote_nak, bus.ballot_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.busy, bus.vote_ack, bus.vote_nak, bus.ballot_valid});
    end
    total++;
    if (bus.voted_mask !== 5'b0) begin
      bad++;
      $display("FAIL reset_mask: got %b expected 00000", bus.voted_mask);
    end
    total++;
    if (ballots_flat() !== 15'b0) begin
      bad++;
      $display("FAIL reset_ballots: got %b expected 0", ballots_flat());
    end
    rst = 1'b0;
  endtask

  task automatic run_full_round(input string tag);
    int sels [5] = '{0, 1, 0, 2, 0};
    int acks;
    int naks;
    acks = 0;
    naks = 0;
    clear_inputs();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy: got %b expected 1", tag, bus.busy);
    end
    bus.ballot_ready = 1'b1;  // early ready must not matter while collecting
    for (int k = 0; k < 5; k++) begin
      set_vote(1'b1, k, sels[k]);
      tick();
      acks += int'(bus.vote_ack);
      naks += int'(bus.vote_nak);
      if (k < 4) begin
        total++;
        if (bus.ballot_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s_early_valid: vote %0d got %b expected 0", tag, k, bus.ballot_valid);
        end
      end
    end
    set_vote(1'b0, 0, 0);
    total++;
    if (acks != 5 || naks != 0) begin
      bad++;
      $display("FAIL %s_acks: got acks=%0d naks=%0d expected 5/0", tag, acks, naks);
    end
    total++;
    if (bus.ballot_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_valid: got %b expected 1", tag, bus.ballot_valid);
    end
    total++;
    if (ballots_flat() !== 15'b001_010_001_100_001) begin
      bad++;
      $display("FAIL %s_ballots: got %b expected 001010001100001", tag, ballots_flat());
    end
    tick();
    total++;
    if ({bus.ballot_valid, bus.busy} !== 2'b00) begin
      bad++;
      $display("FAIL %s_release: got valid/busy %b expected 00", tag, {bus.ballot_valid, bus.busy});
    end
    bus.ballot_ready = 1'b0;
    tick();
    total++;
    if (ballots_flat() !== 15'b001_010_001_100_001) begin
      bad++;
      $display("FAIL %s_idle_hold: got %b expected 001010001100001", tag, ballots_flat());
    end
  endtask

  task automatic test_rejections();
    int  ids  [4] = '{1, 1, 5, 2};
    int  sels [4] = '{1, 2, 0, 3};
    bit  exp_ack;
    int  n;
    clear_inputs();
    bus.start = 1'b1;
    set_vote(1'b1, 0, 0);
    tick();
    bus.start = 1'b0;
    total++;
    if ({bus.vote_ack, bus.vote_nak, bus.voted_mask} !== 7'b01_00000) begin
      bad++;
      $display("FAIL rej_start_vote: got ack/nak/mask %b expected 0100000",
               {bus.vote_ack, bus.vote_nak, bus.voted_mask});
    end
    for (int k = 0; k < 4; k++) begin
      set_vote(1'b1, ids[k], sels[k]);
      tick();
      exp_ack = (k == 0);
      total++;
      if ({bus.vote_ack, bus.vote_nak} !== {exp_ack, !exp_ack}) begin
        bad++;
        $display("FAIL rej_vote%0d: got ack/nak %b expected %b", k,
                 {bus.vote_ack, bus.vote_nak}, {exp_ack, !exp_ack});
      end
    end
    set_vote(1'b0, 0, 0);
    total++;
    if (bus.voted_mask !== 5'b00010) begin
      bad++;
      $display("FAIL rej_mask: got %b expected 00010", bus.voted_mask);
    end
    total++;
    if (ballots_flat() !== 15'b000_010_000_000_000) begin
      bad++;
      $display("FAIL rej_ballots: got %b expected 000010000000000", ballots_flat());
    end
    n = 0;
    while (bus.ballot_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (bus.ballot_valid !== 1'b1) begin
      bad++;
      $display("FAIL rej_drain: round never closed, valid=%b expected 1", bus.ballot_valid);
    end
    bus.ballot_ready = 1'b1;
    tick();
    bus.ballot_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    clear_inputs();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1;
    set_vote(1'b1, 3, 1);
    tick();
    n++;
    set_vote(1'b0, 0, 0);
    while (bus.ballot_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n != int'(TO) + 1) begin
      bad++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TO + 1);
    end
    total++;
    if (ballots_flat() !== 15'b000_000_000_010_000) begin
      bad++;
      $display("FAIL timeout_ballots: got %b expected 000000000010000", ballots_flat());
    end
  endtask

  // Entered with the timeout round sitting in CLOSED.
  task automatic test_handshake_hold();
    bit exp_nak;
    for (int i = 0; i < 10; i++) begin
      exp_nak = (i % 2) == 1;
      bus.ballot_ready = 1'b0;
      bus.start        = (i == 4);
      set_vote(exp_nak, i % 5, i % 3);
      tick();
      total++;
      if ({bus.ballot_valid, bus.busy, bus.vote_ack, bus.vote_nak} !== {3'b110, exp_nak}) begin
        bad++;
        $display("FAIL hold_flags%0d: got %b expected %b", i,
                 {bus.ballot_valid, bus.busy, bus.vote_ack, bus.vote_nak}, {3'b110, exp_nak});
      end
      total++;
      if (ballots_flat() !== 15'b000_000_000_010_000) begin
        bad++;
        $display("FAIL hold_ballots%0d: got %b expected 000000000010000", i, ballots_flat());
      end
    end
    clear_inputs();
    bus.ballot_ready = 1'b1;
    tick();
    bus.ballot_ready = 1'b0;
    total++;
    if ({bus.ballot_valid, bus.busy} !== 2'b00) begin
      bad++;
      $display("FAIL hold_release: got valid/busy %b expected 00", {bus.ballot_valid, bus.busy});
    end
  endtask

  task automatic test_collision();
    clear_inputs();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c <= 4)      set_vote(1'b1, c - 1, c % 3);
      else if (c == 8) set_vote(1'b1, 4, 2);
      else             set_vote(1'b0, 0, 0);
      tick();
      if (c < 8) begin
        total++;
        if (bus.ballot_valid !== 1'b0) begin
          bad++;
          $display("FAIL coll_early_valid%0d: got %b expected 0", c, bus.ballot_valid);
        end
      end
    end
    set_vote(1'b0, 0, 0);
    total++;
    if ({bus.vote_ack, bus.vote_nak, bus.voted_mask, bus.ballot_valid} !== 8'b10_11111_1) begin
      bad++;
      $display("FAIL coll_last_vote: got ack/nak/mask/valid %b expected 10111111",
               {bus.vote_ack, bus.vote_nak, bus.voted_mask, bus.ballot_valid});
    end
    total++;
    if (ballots_flat() !== 15'b010_100_001_010_100) begin
      bad++;
      $display("FAIL coll_ballots: got %b expected 010100001010100", ballots_flat());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.ballot_valid, bus.vote_ack} !== 2'b10) begin
        bad++;
        $display("FAIL coll_stay%0d: got valid/ack %b expected 10", i, {bus.ballot_valid, bus.vote_ack});
      end
    end
    bus.ballot_ready = 1'b1;
    tick();
    bus.ballot_ready = 1'b0;
    tick();
    total++;
    if ({bus.ballot_valid, bus.busy} !== 2'b00) begin
      bad++;
      $display("FAIL coll_once: got valid/busy %b expected 00", {bus.ballot_valid, bus.busy});
    end
  endtask

  task automatic test_reset_mid_round();
    clear_inputs();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    set_vote(1'b1, 0, 0);
    tick();
    set_vote(1'b1, 1, 1);
    tick();
    set_vote(1'b0, 0, 0);
    total++;
    if (bus.voted_mask !== 5'b00011) begin
      bad++;
      $display("FAIL mid_pre_mask: got %b expected 00011", bus.voted_mask);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bus.busy, bus.ballot_valid, bus.voted_mask, ballots_flat()} !== 22'b0) begin
      bad++;
      $display("FAIL mid_reset: got busy/valid/mask/ballots %b expected 0",
               {bus.busy, bus.ballot_valid, bus.voted_mask, ballots_flat()});
    end
    run_full_round("after_rst");
  endtask

  task automatic test_random();
    bit st;
    bit vv;
    bit rdy;
    int id;
    int sel;
    logic [23:0] got;
    logic [23:0] exp;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      st  = ($urandom_range(0, 5) == 0);
      vv  = $urandom_range(0, 1) == 1;
      id  = int'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) == 0);
      bus.start        = st;
      bus.ballot_ready = rdy;
      set_vote(vv, id, sel);
      tick();
      model_edge(st, vv, id, sel, rdy);
      got = {bus.busy, bus.vote_ack, bus.vote_nak, bus.ballot_valid, bus.voted_mask, ballots_flat()};
      exp = model_outputs();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random_cyc%0d: got %b expected %b", cyc, got, exp);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    run_full_round("full");
    test_rejections();
    test_timeout();
    test_handshake_hold();
    test_collision();
    test_reset_mid_round();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
